// File: rtl/serial_link_pkg.sv
// Shared definitions for the bit-serial link (transmitter and matching receiver).
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package serial_link_pkg;

  // Transmitter FSM encoding; the receiver decodes the same two phases.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } tx_state_e;

  localparam int DEFAULT_WIDTH = 4;

  // Bit-order selectors shared with the receiver so both ends agree.
  localparam bit BIT_ORDER_MSB_FIRST = 1'b1;
  localparam bit BIT_ORDER_LSB_FIRST = 1'b0;

  // Bit-index counter width; a 1-bit word still needs a 1-bit counter.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/tx_bit_counter.sv
// Bit-position counter for a WIDTH-bit serial word; wraps to 0 after WIDTH-1.
// Latency: cnt updates one clock after en/clear; at_last is combinational from cnt.
// Backpressure: none, advances whenever en=1; clear has priority over en.
// Ports: clk, rst (sync, active-high), clear, en -> cnt, at_last (cnt==WIDTH-1).
module tx_bit_counter
  import serial_link_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CW = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          at_last
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign at_last = (cnt_q == LAST);

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out transmitter: one WIDTH-bit word out as WIDTH consecutive bits.
// Latency: word accepted in cycle N shows bit k on sout in cycle N+1+k (all outputs registered).
// Backpressure: load_ready only in IDLE or on the final bit, so words stream gaplessly.
// Ports: clk, rst (sync, active-high); load_valid/load_ready/din load handshake;
//        sout, sout_valid, sout_last serial output (sout=IDLE_LEVEL when not valid).
module piso_serial_tx
  import serial_link_pkg::*;
#(
  parameter int   WIDTH      = DEFAULT_WIDTH,
  parameter bit   MSB_FIRST  = BIT_ORDER_MSB_FIRST,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             sout_last_q, sout_last_d;
  logic [CW-1:0]    cnt;
  logic             at_last;
  logic             accept;

  // Ready depends only on registered state and rst, never on load_valid.
  assign load_ready = !rst && ((state_q == ST_IDLE) || at_last);
  assign accept     = load_valid && load_ready;

  // cnt tracks the index of the bit currently on sout; an accept restarts it.
  tx_bit_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .en      (state_q == ST_SHIFT),
    .cnt     (cnt),
    .at_last (at_last)
  );

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    sout_d       = IDLE_LEVEL;
    sout_valid_d = 1'b0;
    sout_last_d  = 1'b0;
    if (accept) begin
      // First bit goes straight to the output register; the rest park in shreg
      // aligned so the next bit always sits at the outgoing end.
      state_d      = ST_SHIFT;
      sout_valid_d = 1'b1;
      sout_last_d  = (WIDTH == 1);
      if (MSB_FIRST) begin
        sout_d  = din[WIDTH-1];
        shreg_d = din << 1;
      end else begin
        sout_d  = din[0];
        shreg_d = din >> 1;
      end
    end else if ((state_q == ST_SHIFT) && !at_last) begin
      sout_valid_d = 1'b1;
      // The bit being registered now has index cnt+1.
      sout_last_d  = ((cnt + CW'(1)) == LAST);
      if (MSB_FIRST) begin
        sout_d  = shreg_q[WIDTH-1];
        shreg_d = shreg_q << 1;
      end else begin
        sout_d  = shreg_q[0];
        shreg_d = shreg_q >> 1;
      end
    end else if (state_q == ST_SHIFT) begin
      // Final bit shown and nothing new accepted: fall back to idle.
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      sout_q       <= IDLE_LEVEL;
      sout_valid_q <= 1'b0;
      sout_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      sout_last_q  <= sout_last_d;
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign sout_last  = sout_last_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx: three instances (W4 MSB-first, W4 LSB-first idle-high, W1).
// A queue of expected {last,bit} entries per instance models the serial stream.
// Directed scenarios first, then randomized traffic with occasional resets.
module tb_piso_serial_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       lv0, lr0, so0, sv0, sl0;
  logic [3:0] din0;
  logic       lv1, lr1, so1, sv1, sl1;
  logic [3:0] din1;
  logic       lv2, lr2, so2, sv2, sl2;
  logic [0:0] din2;

  piso_serial_tx #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .rst(rst), .load_valid(lv0), .load_ready(lr0), .din(din0),
    .sout(so0), .sout_valid(sv0), .sout_last(sl0));

  piso_serial_tx #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .load_valid(lv1), .load_ready(lr1), .din(din1),
    .sout(so1), .sout_valid(sv1), .sout_last(sl1));

  piso_serial_tx #(.WIDTH(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_w1 (
    .clk(clk), .rst(rst), .load_valid(lv2), .load_ready(lr2), .din(din2),
    .sout(so2), .sout_valid(sv2), .sout_last(sl2));

  int checks = 0;
  int errors = 0;

  // Model: front entry is the bit currently on sout; entry = {last, bit}.
  int q0[$], q1[$], q2[$];
  bit acc0, acc1, acc2;

  // Observed-stream collectors for the directed scenarios.
  logic [7:0] coll0, coll1, coll2;
  int nlast0, nlast1, nlast2, nbits0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int entry(input logic [3:0] w, input int width, input bit msb, input int k);
    int idx;
    idx = msb ? (width - 1 - k) : k;
    return ((k == width - 1) ? 2 : 0) + (w[idx] ? 1 : 0);
  endfunction

  task automatic chk_inst(input string name, input int front, input int size, input logic idle,
                          input logic s, input logic v, input logic l, input logic r);
    chk({name, ".sout"},       {31'd0, s}, (size > 0) ? front & 1 : {31'd0, idle});
    chk({name, ".sout_valid"}, {31'd0, v}, (size > 0) ? 1 : 0);
    chk({name, ".sout_last"},  {31'd0, l}, (size > 0 && front >= 2) ? 1 : 0);
    chk({name, ".load_ready"}, {31'd0, r}, (!rst && size <= 1) ? 1 : 0);
  endtask

  // One clock: check all outputs mid-cycle, then advance the model at the edge.
  task automatic cycle();
    @(negedge clk);
    chk_inst("msb", (q0.size() > 0) ? q0[0] : 0, q0.size(), 1'b0, so0, sv0, sl0, lr0);
    chk_inst("lsb", (q1.size() > 0) ? q1[0] : 0, q1.size(), 1'b1, so1, sv1, sl1, lr1);
    chk_inst("w1",  (q2.size() > 0) ? q2[0] : 0, q2.size(), 1'b0, so2, sv2, sl2, lr2);
    if (sv0 === 1'b1) begin coll0 = {coll0[6:0], so0}; nbits0++; if (sl0 === 1'b1) nlast0++; end
    if (sv1 === 1'b1) begin coll1 = {coll1[6:0], so1}; if (sl1 === 1'b1) nlast1++; end
    if (sv2 === 1'b1) begin coll2 = {coll2[6:0], so2}; if (sl2 === 1'b1) nlast2++; end
    @(posedge clk);
    acc0 = lv0 && !rst && (q0.size() <= 1);
    acc1 = lv1 && !rst && (q1.size() <= 1);
    acc2 = lv2 && !rst && (q2.size() <= 1);
    if (rst) begin
      q0.delete(); q1.delete(); q2.delete();
    end else begin
      if (q0.size() > 0) void'(q0.pop_front());
      if (q1.size() > 0) void'(q1.pop_front());
      if (q2.size() > 0) void'(q2.pop_front());
      if (acc0) for (int k = 0; k < 4; k++) q0.push_back(entry(din0, 4, 1'b1, k));
      if (acc1) for (int k = 0; k < 4; k++) q1.push_back(entry(din1, 4, 1'b0, k));
      if (acc2) q2.push_back(entry({3'b000, din2}, 1, 1'b1, 0));
    end
    #1;
  endtask

  initial begin
    int waited;
    rst = 1'b1;
    lv0 = 1'b0; lv1 = 1'b0; lv2 = 1'b0;
    din0 = '0; din1 = '0; din2 = '0;
    @(posedge clk); #1;

    // Reset held: all outputs at reset values, load_ready low.
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // MSB-first single word 1011.
    coll0 = '0; nlast0 = 0;
    lv0 = 1'b1; din0 = 4'b1011;
    cycle();
    lv0 = 1'b0; din0 = 4'b0000;
    repeat (6) cycle();
    chk("msb_1011_stream", {28'd0, coll0[3:0]}, 32'hB);
    chk("msb_1011_lasts", nlast0, 1);

    // Gapless A then 5, second word accepted on A's final bit.
    coll0 = '0; nlast0 = 0;
    lv0 = 1'b1; din0 = 4'hA;
    cycle();
    din0 = 4'h5;
    waited = 0;
    acc0 = 1'b0;
    for (int i = 0; i < 8 && !acc0; i++) begin
      cycle();
      waited++;
    end
    chk("gapless_accept_cycle", waited, 4);
    lv0 = 1'b0;
    repeat (6) cycle();
    chk("gapless_stream", {24'd0, coll0}, 32'hA5);
    chk("gapless_lasts", nlast0, 2);

    // LSB-first 0001 with din toggling while shifting.
    coll1 = '0; nlast1 = 0;
    lv1 = 1'b1; din1 = 4'b0001;
    cycle();
    lv1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      din1 = 4'($urandom);
      cycle();
    end
    chk("lsb_0001_stream", {28'd0, coll1[3:0]}, 32'h8);
    chk("lsb_0001_lasts", nlast1, 1);

    // Reset during the second bit of F aborts the rest of the word.
    lv0 = 1'b1; din0 = 4'hF;
    cycle();
    lv0 = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    nbits0 = 0;
    repeat (5) cycle();
    chk("abort_no_bits", nbits0, 0);

    // WIDTH=1 streaming 1,0,1 with load_valid held.
    coll2 = '0; nlast2 = 0;
    lv2 = 1'b1;
    din2 = 1'b1; cycle();
    din2 = 1'b0; cycle();
    din2 = 1'b1; cycle();
    lv2 = 1'b0;
    repeat (3) cycle();
    chk("w1_stream", {29'd0, coll2[2:0]}, 32'h5);
    chk("w1_lasts", nlast2, 3);

    // Randomized traffic; the producer holds its word until accepted.
    for (int i = 0; i < 400; i++) begin
      if (!(lv0 && !acc0)) begin lv0 = ($urandom_range(0, 2) != 0); din0 = 4'($urandom); end
      if (!(lv1 && !acc1)) begin lv1 = ($urandom_range(0, 2) != 0); din1 = 4'($urandom); end
      if (!(lv2 && !acc2)) begin lv2 = ($urandom_range(0, 2) != 0); din2 = 1'($urandom); end
      rst = ($urandom_range(0, 49) == 0);
      cycle();
    end
    rst = 1'b0; lv0 = 1'b0; lv1 = 1'b0; lv2 = 1'b0;
    repeat (6) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
